// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and field-offset helpers for the matrix loader
// and the determinant wrappers that slice its packed output word.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_2X2  = 4;
    localparam int N_3X3  = 9;
    localparam int MAT_W  = N_3X3 * ELEM_W;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // a11 sits in the top byte of the active width; later elements follow row-major.
    localparam int A11_LSB_2X2 = (N_2X2 - 1) * ELEM_W;
    localparam int A11_LSB_3X3 = (N_3X3 - 1) * ELEM_W;

    function automatic int elem_lsb(input int dim, input int row, input int col);
        return (dim * dim - 1 - (row * dim + col)) * ELEM_W;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// Serial-to-packed front-end: collects 4 or 9 signed elements per frame over a
// valid/ready/last stream, presents the packed matrix, and flags malformed frames.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              size_3x3,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [MAT_W-1:0]  mat_out,
    output logic              mat_is_3x3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err
);

    state_t             state, state_nxt;
    logic [3:0]         count, count_nxt;
    logic [MAT_W-1:0]   shreg, shreg_nxt;
    logic               size_q, size_nxt;
    logic               err_q, err_nxt;
    logic               accept;
    logic               frame_3x3;
    logic [3:0]         last_idx;

    // Handshake outputs decode the state register only, never the live inputs.
    assign in_ready   = (state != ST_HOLD);
    assign out_valid  = (state == ST_HOLD);
    assign accept     = in_valid && in_ready;
    assign mat_out    = shreg;
    assign mat_is_3x3 = size_q;
    assign frame_err  = err_q;

    // Size is taken live on the first beat, from the latched copy afterwards.
    assign frame_3x3 = (count == 4'd0) ? size_3x3 : size_q;
    assign last_idx  = frame_3x3 ? 4'(N_3X3 - 1) : 4'(N_2X2 - 1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        count_nxt = count;
        shreg_nxt = shreg;
        size_nxt  = size_q;
        err_nxt   = 1'b0;

        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (count == 4'd0) begin
                        size_nxt  = size_3x3;
                        shreg_nxt = {{(MAT_W - ELEM_W){1'b0}}, in_data};
                    end else begin
                        shreg_nxt = {shreg[MAT_W-ELEM_W-1:0], in_data};
                    end

                    if (count == last_idx) begin
                        count_nxt = 4'd0;
                        if (in_last) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (in_last) begin
                        err_nxt   = 1'b1;
                        count_nxt = 4'd0;
                    end else begin
                        count_nxt = count + 4'd1;
                    end
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_FILL;
                    count_nxt = 4'd0;
                end
            end

            ST_DRAIN: begin
                if (accept && in_last) begin
                    state_nxt = ST_FILL;
                    count_nxt = 4'd0;
                end
            end

            default: begin
                state_nxt = ST_FILL;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
        if (rst) begin
            state  <= ST_FILL;
            count  <= 4'd0;
            shreg  <= '0;
            size_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            shreg  <= shreg_nxt;
            size_q <= size_nxt;
            err_q  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table-driven frames with a scoreboard
// of expected output words, plus hand sequences for backpressure and reset.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        size_3x3;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [71:0] mat_out;
    logic        mat_is_3x3;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;

    matrix_loader dut (
        .clk        (clk),
        .rst        (rst),
        .size_3x3   (size_3x3),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mat_out    (mat_out),
        .mat_is_3x3 (mat_is_3x3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sz;
        logic [71:0] elems;     // first beat in [71:64]
        int          n;
        int          last_pos;  // beat index carrying in_last, -1 for none
        bit          good;
        logic [71:0] exp;
    } vec_t;

    typedef struct {
        logic [71:0] mat;
        logic        is3;
    } exp_t;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   err_seen = 0;
    int   err_exp  = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor samples 1 ns after the falling edge, after any driver update.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (frame_err === 1'b1) err_seen++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h, want no output", mat_out);
                end else begin
                    e = q.pop_front();
                    check("mat_out", mat_out, e.mat);
                    check("mat_is_3x3", {71'd0, mat_is_3x3}, {71'd0, e.is3});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input logic [7:0] d, input logic last, input logic sz);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        size_3x3 = sz;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic send(input vec_t v);
        logic [71:0] tmp;
        for (int i = 0; i < v.n; i++) begin
            tmp = v.elems << (8 * i);
            // Later beats carry the opposite size bit, which must be ignored.
            drive_beat(tmp[71:64], (i == v.last_pos), (i == 0) ? v.sz : ~v.sz);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;
        vec_t v;

        vecs[0] = '{1'b0, {8'h01, 8'h02, 8'h03, 8'h04, 40'h0}, 4, 3, 1'b1, 72'h00_0000_0000_0102_0304};
        vecs[1] = '{1'b1, 72'h01_0203_0405_0607_0809, 9, 8, 1'b1, 72'h01_0203_0405_0607_0809};
        vecs[2] = '{1'b1, 72'h11_1213_1415_0000_0000, 5, 4, 1'b0, 72'h0};
        vecs[3] = '{1'b0, {8'h05, 8'h06, 8'h07, 8'h08, 40'h0}, 4, 3, 1'b1, 72'h00_0000_0000_0506_0708};
        vecs[4] = '{1'b0, 72'h21_2223_2425_2627_0000, 7, 6, 1'b0, 72'h0};
        vecs[5] = '{1'b0, {8'h0A, 8'h0B, 8'h0C, 8'h0D, 40'h0}, 4, 3, 1'b1, 72'h00_0000_0000_0A0B_0C0D};
        vecs[6] = '{1'b1, 72'h80_FF7F_0001_FE81_7E55, 9, 8, 1'b1, 72'h80_FF7F_0001_FE81_7E55};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        size_3x3  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mat_out", mat_out, 72'h0);
        check("rst_is3", {71'd0, mat_is_3x3}, 72'h0);
        check("rst_out_valid", {71'd0, out_valid}, 72'h0);
        check("rst_frame_err", {71'd0, frame_err}, 72'h0);
        check("rst_in_ready", {71'd0, in_ready}, 72'h1);

        for (int k = 0; k < 7; k++) begin
            v = vecs[k];
            if (v.good) begin
                e.mat = v.exp;
                e.is3 = v.sz;
                q.push_back(e);
            end else begin
                err_exp++;
            end
            send(v);
            wait_drain();
            check($sformatf("frame_err_count_v%0d", k), 72'(err_seen), 72'(err_exp));
        end

        // Backpressure: hold a 2x2 frame for 5 cycles while junk beats are offered.
        out_ready = 1'b0;
        v = '{1'b0, {8'hFF, 8'h80, 8'h7F, 8'h00, 40'h0}, 4, 3, 1'b1, 72'h0};
        e.mat = 72'h00_0000_0000_FF80_7F00;
        e.is3 = 1'b0;
        q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            logic [71:0] tmp;
            tmp = v.elems << (8 * i);
            drive_beat(tmp[71:64], (i == 3), 1'b0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h33;
            in_last  = 1'b1;
            #1;
            check("bp_out_valid", {71'd0, out_valid}, 72'h1);
            check("bp_in_ready", {71'd0, in_ready}, 72'h0);
            check("bp_mat_out", mat_out, 72'h00_0000_0000_FF80_7F00);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("post_hs_in_ready", {71'd0, in_ready}, 72'h1);
        check("post_hs_out_valid", {71'd0, out_valid}, 72'h0);
        wait_drain();
        check("bp_frame_err_count", 72'(err_seen), 72'(err_exp));

        // Reset after 2 of 4 elements abandons the frame silently.
        drive_beat(8'h99, 1'b0, 1'b0);
        drive_beat(8'h98, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_mat_out", mat_out, 72'h0);
        check("midrst_out_valid", {71'd0, out_valid}, 72'h0);
        check("midrst_in_ready", {71'd0, in_ready}, 72'h1);
        check("midrst_frame_err", {71'd0, frame_err}, 72'h0);
        v = '{1'b0, {8'h11, 8'h22, 8'h33, 8'h44, 40'h0}, 4, 3, 1'b1, 72'h0};
        e.mat = 72'h00_0000_0000_1122_3344;
        e.is3 = 1'b0;
        q.push_back(e);
        send(v);
        wait_drain();
        check("final_frame_err_count", 72'(err_seen), 72'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Sequential front-end that assembles a packed matrix word for the 2x2/3x3 determinant units from a serial stream of signed 8-bit elements. Elements arrive one per accepted beat in row-major order, over a valid/ready/last handshake. The loader emits the packed word on a valid/ready output port and rejects malformed frames. It sits between the element source (host/UART/register front-end) and the combinational determinant blocks.

## Interface
- ELEM_W, 8, element width in bits (signed two's complement); fixed by determinant units
- MAT_W, 72, packed output width (9 × ELEM_W)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- size_3x3  input  1  matrix size for the frame: 0 = 2x2 (4 elements), 1 = 3x3 (9 elements); sampled only when the first element of a frame is accepted
- in_data  input  8  signed element
- in_valid  input  1  element present
- in_last  input  1  marks the final element of a frame
- in_ready  output  1  loader accepts an element this cycle
- mat_out  output  72  packed matrix; a11 in the top byte of the active width; unused upper bits are 0 (2x2 uses [31:0])
- mat_is_3x3  output  1  size of the frame in mat_out
- out_valid  output  1  mat_out holds a complete frame
- out_ready  input  1  consumer accepts mat_out
- frame_err  output  1  one-cycle pulse on a malformed frame

## Operation
- States:
  - FILL: collecting elements.
  - HOLD: complete matrix presented.
  - DRAIN: discarding the rest of a bad frame.
- Accept = in_valid && in_ready. in_ready = 1 in FILL and DRAIN, 0 in HOLD.
- Packing in FILL:
  - On each accept, shift reg ← (reg << 8) | in_data.
  - Count increments from 0; N = 4 or 9, taken from the latched size.
  - On the first accept (count = 0), shift reg is cleared before insertion and size_3x3 is latched.
- Good frame: accept with count = N−1 and in_last = 1 → HOLD. mat_out = shift reg, out_valid = 1.
- Early last: accept with in_last = 1 and count < N−1.
  - Frame discarded, frame_err pulses, count ← 0.
  - Stay in FILL.
- Missing last: accept with count = N−1 and in_last = 0.
  - Frame discarded, frame_err pulses → DRAIN.
- DRAIN:
  - Accepts and drops elements; no frame_err for dropped beats.
  - On an accept with in_last = 1 → FILL, count ← 0.
- HOLD: mat_out and mat_is_3x3 stay stable while out_valid && !out_ready. On out_valid && out_ready → FILL, count ← 0.
- Arithmetic: no sign extension or saturation. Elements are stored bit-exact; the upper MAT_W − 8N bits are 0.
- Reset values:
  - state = FILL, count = 0
  - mat_out = 0, mat_is_3x3 = 0
  - out_valid = 0, frame_err = 0
  - in_ready = 1 on the first cycle after reset release.
- Reset mid-operation: any partial frame, held frame or drain is abandoned; no frame_err is generated.

## Timing
- in_ready and out_valid are registered state decodes, not combinational from in_valid or out_ready.
- Latency: out_valid rises the cycle after the accept of the last element.
- The cycle after an out handshake, in_ready = 1 and out_valid = 0. There is no same-cycle bypass from HOLD to FILL.
- Throughput: one frame per N + 1 cycles at best (N accepts + 1 HOLD cycle with out_ready = 1).
- frame_err is registered: high exactly the cycle after the offending accept.
- in_data, in_last and size_3x3 are ignored when in_valid = 0 or in_ready = 0.
- A size_3x3 change mid-frame has no effect.

## Structure
- Shared package/header `matrix_pkg`:
  - ELEM_W = 8, N_2X2 = 4, N_3X3 = 9, MAT_W = 72
  - State encodings FILL / HOLD / DRAIN
  - Field offset helper constants, also used by determinante_2x2/3x3 wrappers to slice mat_out
- Single module, no sub-module: 72-bit shift register, 4-bit counter, 2-bit state register.

## Test plan
- 2x2 good frame: size_3x3 = 0; elements 1, 2, 3, 4; last on the 4th → out_valid next cycle, mat_out = 72'h00_0000_0000_0102_0304, mat_is_3x3 = 0.
- 3x3 good frame: elements 01..09, out_ready held 1 → mat_out = 72'h01_0203_0405_0607_0809, mat_is_3x3 = 1; in_ready back to 1 one cycle after handshake.
- Backpressure: complete 2x2 {FF, 80, 7F, 00}, out_ready = 0 for 5 cycles.
  - mat_out stable at 0x..FF807F00, out_valid = 1, in_ready = 0 throughout.
  - Elements driven with in_valid = 1 during HOLD are not accepted.
- Early last: 3x3 frame with in_last on the 5th element → frame_err pulse, no out_valid; next good 2x2 frame {05, 06, 07, 08} yields 0x05060708.
- Missing last: 2x2 frame with no in_last on the 4th element → frame_err pulse.
  - The 3 following elements are dropped, the last of them carrying in_last.
  - The next frame packs correctly.
- Reset mid-frame: rst asserted after 2 of 4 elements → all outputs 0, in_ready = 1, no frame_err; a fresh 4-element frame packs correctly.
